// File: rtl/universal_shift_register_n_bit_if.sv
// Bus bundle for universal_shift_register_n_bit: control, serial and parallel
// data, and the word-framing status outputs. Clock and reset stay outside.
interface universal_shift_register_n_bit_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             Enable_In;
    logic [1:0]       Mode_In;
    logic             Serial_Data_In;
    logic [WIDTH-1:0] Parallel_Data_In;
    logic [WIDTH-1:0] Parallel_Data_Out;
    logic             Serial_Data_Out;
    logic [CNT_W-1:0] Bit_Count_Out;
    logic             Word_Valid_Out;

    // Driver side: issues commands and data, observes the register.
    modport master (
        output Enable_In,
        output Mode_In,
        output Serial_Data_In,
        output Parallel_Data_In,
        input  Parallel_Data_Out,
        input  Serial_Data_Out,
        input  Bit_Count_Out,
        input  Word_Valid_Out
    );

    // Register side.
    modport slave (
        input  Enable_In,
        input  Mode_In,
        input  Serial_Data_In,
        input  Parallel_Data_In,
        output Parallel_Data_Out,
        output Serial_Data_Out,
        output Bit_Count_Out,
        output Word_Valid_Out
    );
endinterface

// File: rtl/universal_shift_register_n_bit.sv
// Universal shift register: hold, shift-left, shift-right and parallel load.
// Counts shifts modulo WIDTH and strobes Word_Valid_Out on the shift that
// completes a WIDTH-bit word. Parallel output floats while disabled.
module universal_shift_register_n_bit #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input logic                            Clk_In,
    input logic                            Reset_In,
    universal_shift_register_n_bit_if.slave bus
);
    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LEFT  = 2'b01,
        MODE_RIGHT = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_e;

    mode_e            mode;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] cnt_q;
    logic             word_valid_q;

    assign mode = mode_e'(bus.Mode_In);

    // Next register value for a shift in the currently selected direction.
    always_comb begin
        shifted = data_q;
        if (mode == MODE_RIGHT) begin
            shifted = {bus.Serial_Data_In, data_q[WIDTH-1:1]};
        end else begin
            shifted = {data_q[WIDTH-2:0], bus.Serial_Data_In};
        end
    end

    // Register, shift counter and word strobe; reset wins over enable over mode.
    always_ff @(posedge Clk_In) begin
        if (Reset_In) begin
            data_q       <= RESET_VALUE;
            cnt_q        <= '0;
            word_valid_q <= 1'b0;
        end else if (bus.Enable_In) begin
            case (mode)
                MODE_HOLD: begin
                    word_valid_q <= 1'b0;
                end
                MODE_LEFT, MODE_RIGHT: begin
                    data_q <= shifted;
                    // Wrap at WIDTH so the strobe lands on the completing shift
                    // even when WIDTH is not a power of two.
                    if (cnt_q == LAST_CNT) begin
                        cnt_q        <= '0;
                        word_valid_q <= 1'b1;
                    end else begin
                        cnt_q        <= cnt_q + 1'b1;
                        word_valid_q <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    data_q       <= bus.Parallel_Data_In;
                    cnt_q        <= '0;
                    word_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Parallel_Data_Out = bus.Enable_In ? data_q : 'z;
    assign bus.Serial_Data_Out   = (mode == MODE_RIGHT) ? data_q[0] : data_q[WIDTH-1];
    assign bus.Bit_Count_Out     = cnt_q;
    assign bus.Word_Valid_Out    = word_valid_q;
endmodule

// File: tb/tb_universal_shift_register_n_bit.sv
// Self-checking bench for universal_shift_register_n_bit (WIDTH=8).
// Directed vector table, hand-written multi-cycle sequences, then random
// stimulus compared against an arithmetic reference model.
module tb_universal_shift_register_n_bit;
    localparam int unsigned W    = 8;
    localparam int unsigned MASK = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    universal_shift_register_n_bit_if #(.WIDTH(W)) bus ();

    universal_shift_register_n_bit #(
        .WIDTH       (W),
        .RESET_VALUE (8'h00)
    ) dut (
        .Clk_In   (clk),
        .Reset_In (rst),
        .bus      (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: register as an integer, shift count since the last boundary.
    int unsigned m_reg = 0;
    int unsigned m_cnt = 0;
    logic        m_wv  = 1'b0;

    typedef struct {
        logic        r;
        logic        en;
        logic [1:0]  mode;
        logic        si;
        logic [7:0]  pdi;
        logic [7:0]  pdo;
        int unsigned cnt;
        logic        wv;
        logic        so;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic r, logic en, logic [1:0] mode, logic si, logic [7:0] pdi,
                               logic [7:0] pdo, int unsigned cnt, logic wv, logic so);
        vec_t x;
        x.r = r; x.en = en; x.mode = mode; x.si = si; x.pdi = pdi;
        x.pdo = pdo; x.cnt = cnt; x.wv = wv; x.so = so;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Disabled parallel output must float; a two-state simulator resolves the
    // undriven bus to zero, so either reading is accepted, never register data.
    task automatic chk_off(input string name);
        checks++;
        if (!(bus.Parallel_Data_Out === {W{1'bz}} || bus.Parallel_Data_Out === '0)) begin
            failures++;
            $display("FAIL %s actual=%0h expected=z", name, bus.Parallel_Data_Out);
        end
    endtask

    task automatic model_step(input logic r, input logic en, input logic [1:0] mode,
                              input logic si, input logic [7:0] pdi);
        if (r) begin
            m_reg = 0; m_cnt = 0; m_wv = 1'b0;
        end else if (en) begin
            case (mode)
                2'd0: m_wv = 1'b0;
                2'd3: begin m_reg = pdi; m_cnt = 0; m_wv = 1'b0; end
                default: begin
                    if (mode == 2'd1) m_reg = ((m_reg * 2) + si) & MASK;
                    else              m_reg = (m_reg / 2) + (si ? (1 << (W - 1)) : 0);
                    m_cnt = m_cnt + 1;
                    m_wv  = (m_cnt == W);
                    if (m_cnt == W) m_cnt = 0;
                end
            endcase
        end
    endtask

    // Drive inputs on the falling edge, clock once, sample 1 time unit later.
    task automatic cycle(input logic r, input logic en, input logic [1:0] mode,
                         input logic si, input logic [7:0] pdi);
        @(negedge clk);
        rst                  = r;
        bus.Enable_In        = en;
        bus.Mode_In          = mode;
        bus.Serial_Data_In   = si;
        bus.Parallel_Data_In = pdi;
        @(posedge clk);
        model_step(r, en, mode, si, pdi);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        bus.Enable_In = 1'b0;
        bus.Mode_In = 2'b00;
        bus.Serial_Data_In = 1'b0;
        bus.Parallel_Data_In = '0;

        //         r  en mode si pdi    pdo    cnt wv so
        tbl.push_back(v(1, 1, 2'd0, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1, 2'd3, 0, 8'hA5, 8'hA5, 0, 0, 1));
        tbl.push_back(v(1, 1, 2'd3, 0, 8'hFF, 8'h00, 0, 0, 0));
        // left shifts 1,0,1,1,0,0,1,0
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h01, 1, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 0, 8'h00, 8'h02, 2, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h05, 3, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h0B, 4, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 0, 8'h00, 8'h16, 5, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 0, 8'h00, 8'h2C, 6, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h59, 7, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 0, 8'h00, 8'hB2, 0, 1, 1));
        // back-to-back second word of ones
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h65, 1, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'hCB, 2, 0, 1));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h97, 3, 0, 1));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h2F, 4, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h5F, 5, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'hBF, 6, 0, 1));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h7F, 7, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'hFF, 0, 1, 1));
        tbl.push_back(v(0, 1, 2'd0, 0, 8'h00, 8'hFF, 0, 0, 1));
        // right shifts 1,0,1,1,0,0,1,0 from reset
        tbl.push_back(v(1, 1, 2'd2, 0, 8'h00, 8'h00, 0, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 1, 8'h00, 8'h80, 1, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 0, 8'h00, 8'h40, 2, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 1, 8'h00, 8'hA0, 3, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 1, 8'h00, 8'hD0, 4, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 0, 8'h00, 8'h68, 5, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 0, 8'h00, 8'h34, 6, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 1, 8'h00, 8'h9A, 7, 0, 0));
        tbl.push_back(v(0, 1, 2'd2, 0, 8'h00, 8'h4D, 0, 1, 1));
        // load then one left shift
        tbl.push_back(v(0, 1, 2'd3, 0, 8'h3C, 8'h3C, 0, 0, 0));
        tbl.push_back(v(0, 1, 2'd1, 1, 8'h00, 8'h79, 1, 0, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].en, tbl[i].mode, tbl[i].si, tbl[i].pdi);
            chk($sformatf("vec%0d_pdo", i), bus.Parallel_Data_Out, tbl[i].pdo);
            chk($sformatf("vec%0d_cnt", i), bus.Bit_Count_Out, tbl[i].cnt);
            chk($sformatf("vec%0d_wv", i), bus.Word_Valid_Out, tbl[i].wv);
            chk($sformatf("vec%0d_so", i), bus.Serial_Data_Out, tbl[i].so);
        end

        // Serial output follows Mode_In combinationally: LSB of 0x79 in right mode.
        @(negedge clk);
        bus.Mode_In = 2'b10;
        #1;
        chk("so_right_comb", bus.Serial_Data_Out, 1'b1);
        bus.Mode_In = 2'b00;
        #1;
        chk("so_hold_comb", bus.Serial_Data_Out, 1'b0);

        // Enable dropped mid-word: output floats, count held, word completes later.
        cycle(1, 1, 2'd0, 0, 8'h00);
        repeat (3) cycle(0, 1, 2'd1, 1, 8'h00);
        chk("dis_pre_cnt", bus.Bit_Count_Out, 3);
        chk("dis_pre_pdo", bus.Parallel_Data_Out, 8'h07);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 0, 2'd1, 1, 8'h00);
            chk_off($sformatf("dis%0d_pdo", i));
            chk($sformatf("dis%0d_cnt", i), bus.Bit_Count_Out, 3);
            chk($sformatf("dis%0d_wv", i), bus.Word_Valid_Out, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 2'd1, 1, 8'h00);
            chk($sformatf("reen%0d_wv", i), bus.Word_Valid_Out, (i == 4));
        end
        chk("reen_pdo", bus.Parallel_Data_Out, 8'hFF);
        chk("reen_cnt", bus.Bit_Count_Out, 0);
        // Strobe held across a disabled edge, then cleared by an enabled hold.
        cycle(0, 0, 2'd0, 0, 8'h00);
        chk("wv_held", bus.Word_Valid_Out, 1'b1);
        cycle(0, 1, 2'd0, 0, 8'h00);
        chk("wv_cleared", bus.Word_Valid_Out, 1'b0);

        // Reset mid-word discards the partial count; hold mid-word is inert.
        cycle(1, 1, 2'd0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 1, 2'd1, i[0], 8'h00);
        chk("mid_cnt5", bus.Bit_Count_Out, 5);
        cycle(1, 1, 2'd1, 1, 8'h00);
        chk("mid_rst_cnt", bus.Bit_Count_Out, 0);
        chk("mid_rst_pdo", bus.Parallel_Data_Out, 8'h00);
        repeat (3) cycle(0, 1, 2'd1, 1, 8'h00);
        for (int i = 0; i < 2; i++) begin
            cycle(0, 1, 2'd0, 0, 8'h00);
            chk($sformatf("hold%0d_cnt", i), bus.Bit_Count_Out, 3);
            chk($sformatf("hold%0d_wv", i), bus.Word_Valid_Out, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1, 2'd2, 0, 8'h00);
            chk($sformatf("post_rst%0d_wv", i), bus.Word_Valid_Out, (i == 4));
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            logic       r, en, si;
            logic [1:0] mode;
            logic [7:0] pdi;
            int unsigned pick;
            r    = ($urandom_range(0, 24) == 0);
            en   = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 9);
            mode = (pick == 0) ? 2'd0 : (pick <= 4) ? 2'd1 : (pick <= 8) ? 2'd2 : 2'd3;
            si   = 1'($urandom);
            pdi  = 8'($urandom);
            cycle(r, en, mode, si, pdi);
            if (en) chk($sformatf("rnd%0d_pdo", n), bus.Parallel_Data_Out, m_reg);
            else    chk_off($sformatf("rnd%0d_pdo", n));
            chk($sformatf("rnd%0d_cnt", n), bus.Bit_Count_Out, m_cnt);
            chk($sformatf("rnd%0d_wv", n), bus.Word_Valid_Out, m_wv);
            chk($sformatf("rnd%0d_so", n), bus.Serial_Data_Out,
                (mode == 2'd2) ? (m_reg % 2) : ((m_reg >> (W - 1)) % 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/universal_shift_register_n_bit.md
Name: universal_shift_register_n_bit

Overview:
Parametrised universal shift register with four modes: hold, shift-left, shift-right and parallel-load.
- Serves as the general-purpose SIPO/PISO/SISO/PIPO element in the shift-register library.
- Adds a serial output, a shift-count tracker and a one-cycle word-complete strobe for framing serial streams into WIDTH-bit words.
- Parallel output is tri-stated when the block is disabled, for shared-bus use.

Parameters:
- WIDTH, 8, register width in bits; legal range is WIDTH >= 2, and a power of two is not required.
- RESET_VALUE, {WIDTH{1'b0}}, register contents after reset.
- CNT_W, $clog2(WIDTH), width of the shift counter; derived, not overridden.

Ports:
- Clk_In  input  1  clock; all state updates on the rising edge.
- Reset_In  input  1  synchronous reset, active-high.
- Enable_In  input  1  block enable; when low, state is held and Parallel_Data_Out is Z.
- Mode_In  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
- Serial_Data_In  input  1  bit shifted in (into LSB on a left shift, into MSB on a right shift).
- Parallel_Data_In  input  WIDTH  word captured on parallel load.
- Parallel_Data_Out  output  WIDTH  register contents; Z when Enable_In=0.
- Serial_Data_Out  output  1  bit at the exit end of the current shift direction.
- Bit_Count_Out  output  CNT_W  number of shifts since the last word boundary, load or reset.
- Word_Valid_Out  output  1  registered one-cycle strobe: a full WIDTH-bit word has been shifted in.

Behaviour:
- Priority at each rising edge: Reset_In, then Enable_In, then Mode_In.
- Reset (Reset_In=1, regardless of Enable_In or mode):
  - register = RESET_VALUE; Bit_Count_Out = 0; Word_Valid_Out = 0.
  - Reset asserted mid-word discards the partial count.
- Enable_In=0:
  - register, count and Word_Valid_Out are all held.
  - A held Word_Valid_Out is forced to 0 on the next enabled edge unless a new word completes on that edge.
  - Parallel_Data_Out = {WIDTH{1'bz}} combinationally; Serial_Data_Out is not tri-stated.
- Mode 00 (hold): register and count unchanged; Word_Valid_Out = 0.
- Mode 01 (shift left): register = {r[WIDTH-2:0], Serial_Data_In}.
- Mode 10 (shift right): register = {Serial_Data_In, r[WIDTH-1:1]}.
- Mode 11 (parallel load): register = Parallel_Data_In; count = 0; Word_Valid_Out = 0.
- Counter rules, on a shift (mode 01 or 10):
  - If count == WIDTH-1: count becomes 0 and Word_Valid_Out = 1 for exactly that cycle.
  - Otherwise: count increments and Word_Valid_Out = 0.
  - The counter wraps at WIDTH, not at 2^CNT_W.
  - Switching between left and right shift mid-word does not reset the count.
- Word_Valid_Out timing: asserted in the same cycle that Parallel_Data_Out first shows the complete word, i.e. zero latency relative to the register.
- Serial_Data_Out is combinational from the current register: r[0] when Mode_In=10, otherwise r[WIDTH-1].
- Parallel_Data_Out equals the register when enabled, with no extra pipeline stage.
- Back-to-back words: continuous shifting produces a Word_Valid_Out pulse every WIDTH cycles with no dead cycle.

Test Plan (WIDTH=8, RESET_VALUE=0):
1. Load 0xA5, then Reset_In=1 with Mode_In=11 and Parallel_Data_In=0xFF -> Parallel_Data_Out=0x00, Bit_Count_Out=0, Word_Valid_Out=0.
2. Mode 01, shift in 1,0,1,1,0,0,1,0 on 8 edges -> after the 8th edge Parallel_Data_Out=0xB2, Word_Valid_Out=1 for one cycle only, Bit_Count_Out=0. Continue with 8 more shifts -> a second pulse exactly 8 cycles later.
3. Mode 10, same bit sequence from reset -> Parallel_Data_Out=0x4D, Word_Valid_Out pulse on the 8th edge.
4. Load 0x3C (count resets to 0), then one left shift with Serial_Data_In=1 -> Parallel_Data_Out=0x79, Bit_Count_Out=1. Serial_Data_Out=0 before and after the shift. With Mode_In=10, Serial_Data_Out=1 (LSB of 0x79).
5. After 3 left shifts, drop Enable_In for 4 cycles -> Parallel_Data_Out=Z, Bit_Count_Out holds 3. Re-enable and apply 5 more shifts -> Word_Valid_Out pulses on the 5th, i.e. the 8th total shift.
6. After 5 left shifts, assert Reset_In for 1 cycle -> count=0. The next Word_Valid_Out comes only after 8 further shifts. Mode 00 inserted mid-word -> no count change, no pulse.
